// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths and 4-bit ALU opcode encodings,
// used by the ID/EX stage and the ALU.
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;
    localparam int ALUOP_W = 4;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'b1000;
    localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'b0001;
    localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'b1001;
    localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'b1101;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'b0010;
    localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'b0011;
    localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 4'b0110;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 4'b0111;

    // Control bits that travel with an instruction; all zero in a bubble.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
    } ctrl_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding for one source register: EX/MEM beats MEM/WB, x0 never forwarded.
module fwd_mux #(
    parameter int XLEN   = alu_pkg::XLEN,
    parameter int REG_AW = alu_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [XLEN-1:0]   rf_data,
    input  logic              ex_mem_reg_write,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic [XLEN-1:0]   ex_mem_data,
    input  logic              mem_wb_reg_write,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic [XLEN-1:0]   mem_wb_data,
    output logic [XLEN-1:0]   fwd_data
);

    logic ex_mem_hit;
    logic mem_wb_hit;

    assign ex_mem_hit = ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == rs_addr);
    assign mem_wb_hit = mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == rs_addr);

    always_comb begin
        fwd_data = rf_data;
        if (ex_mem_hit)
            fwd_data = ex_mem_data;
        else if (mem_wb_hit)
            fwd_data = mem_wb_data;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, ALU operand select and
// load-use detection. Define ID_EX_PERF_EN to add stall/bubble counters.
module id_ex_stage #(
    parameter int XLEN    = alu_pkg::XLEN,
    parameter int REG_AW  = alu_pkg::REG_AW,
    parameter int ALUOP_W = alu_pkg::ALUOP_W
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iStall,
    input  logic               iFlush,
    input  logic               iValid,
    input  logic [XLEN-1:0]    iPc,
    input  logic [XLEN-1:0]    iRs1Data,
    input  logic [XLEN-1:0]    iRs2Data,
    input  logic [XLEN-1:0]    iImm,
    input  logic [REG_AW-1:0]  iRs1Addr,
    input  logic [REG_AW-1:0]  iRs2Addr,
    input  logic [REG_AW-1:0]  iRdAddr,
    input  logic [ALUOP_W-1:0] iAluOp,
    input  logic               iAluSrcA,
    input  logic               iAluSrcB,
    input  logic               iRegWrite,
    input  logic               iMemRead,
    input  logic               iMemWrite,
    input  logic               iBranch,
    input  logic               iExMemRegWrite,
    input  logic               iMemWbRegWrite,
    input  logic [REG_AW-1:0]  iExMemRd,
    input  logic [REG_AW-1:0]  iMemWbRd,
    input  logic [XLEN-1:0]    iExMemData,
    input  logic [XLEN-1:0]    iMemWbData,
    output logic               oValid,
    output logic [XLEN-1:0]    oDataA,
    output logic [XLEN-1:0]    oDataB,
    output logic [XLEN-1:0]    oStoreData,
    output logic [ALUOP_W-1:0] oAluOp,
    output logic [XLEN-1:0]    oPc,
    output logic [XLEN-1:0]    oImm,
    output logic [REG_AW-1:0]  oRdAddr,
    output logic               oRegWrite,
    output logic               oMemRead,
    output logic               oMemWrite,
    output logic               oBranch,
`ifdef ID_EX_PERF_EN
    output logic [31:0]        oStallCnt,
    output logic [31:0]        oBubbleCnt,
`endif
    output logic               oLoadUseHazard
);

    import alu_pkg::*;

    logic               valid_q;
    logic [XLEN-1:0]    pc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [REG_AW-1:0]  rs1_addr_q, rs2_addr_q, rd_q;
    logic [ALUOP_W-1:0] alu_op_q;
    logic               src_a_q, src_b_q;
    ctrl_t              ctrl_q, ctrl_in;
    logic [XLEN-1:0]    fwd_rs1, fwd_rs2;

    // A slot without a real instruction must not write or touch memory.
    assign ctrl_in = iValid ? ctrl_t'{iRegWrite, iMemRead, iMemWrite, iBranch} : '0;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_q       <= '0;
            alu_op_q   <= ALU_ADD;
            src_a_q    <= 1'b0;
            src_b_q    <= 1'b0;
            ctrl_q     <= '0;
        end else if (iFlush) begin
            // Data fields hold; only what could cause side effects is killed.
            valid_q <= 1'b0;
            rd_q    <= '0;
            ctrl_q  <= '0;
        end else if (!iStall) begin
            valid_q    <= iValid;
            pc_q       <= iPc;
            rs1_data_q <= iRs1Data;
            rs2_data_q <= iRs2Data;
            imm_q      <= iImm;
            rs1_addr_q <= iRs1Addr;
            rs2_addr_q <= iRs2Addr;
            rd_q       <= iValid ? iRdAddr : '0;
            alu_op_q   <= iAluOp;
            src_a_q    <= iAluSrcA;
            src_b_q    <= iAluSrcB;
            ctrl_q     <= ctrl_in;
        end
    end

`ifdef ID_EX_PERF_EN
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oStallCnt  <= '0;
            oBubbleCnt <= '0;
        end else begin
            if (iStall && !iFlush)
                oStallCnt <= oStallCnt + 32'd1;
            if (iFlush || (!iStall && !iValid))
                oBubbleCnt <= oBubbleCnt + 32'd1;
        end
    end
`endif

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs_addr          (rs1_addr_q),
        .rf_data          (rs1_data_q),
        .ex_mem_reg_write (iExMemRegWrite),
        .ex_mem_rd        (iExMemRd),
        .ex_mem_data      (iExMemData),
        .mem_wb_reg_write (iMemWbRegWrite),
        .mem_wb_rd        (iMemWbRd),
        .mem_wb_data      (iMemWbData),
        .fwd_data         (fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs_addr          (rs2_addr_q),
        .rf_data          (rs2_data_q),
        .ex_mem_reg_write (iExMemRegWrite),
        .ex_mem_rd        (iExMemRd),
        .ex_mem_data      (iExMemData),
        .mem_wb_reg_write (iMemWbRegWrite),
        .mem_wb_rd        (iMemWbRd),
        .mem_wb_data      (iMemWbData),
        .fwd_data         (fwd_rs2)
    );

    assign oValid     = valid_q;
    assign oPc        = pc_q;
    assign oImm       = imm_q;
    assign oRdAddr    = rd_q;
    assign oAluOp     = alu_op_q;
    assign oRegWrite  = ctrl_q.reg_write;
    assign oMemRead   = ctrl_q.mem_read;
    assign oMemWrite  = ctrl_q.mem_write;
    assign oBranch    = ctrl_q.branch;
    assign oDataA     = src_a_q ? pc_q  : fwd_rs1;
    assign oDataB     = src_b_q ? imm_q : fwd_rs2;
    assign oStoreData = fwd_rs2;

    assign oLoadUseHazard = valid_q && ctrl_q.mem_read && (rd_q != '0) && iValid &&
                            ((iRs1Addr == rd_q) || (iRs2Addr == rd_q));

endmodule
